// File: rtl/bfp_scale_ctrl_pkg.sv
// Shared types and helpers for the block-floating-point scale controller.
package bfp_pkg;

    // Default datapath geometry
    localparam int FFT_DW_DEFAULT    = 16;
    localparam int FFT_BFPDW_DEFAULT = 5;
    localparam int FFT_EXPW_DEFAULT  = 6;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        PUBLISH
    } bfp_state_t;

    // Bit widths the shifter passes through unshifted: empty stage, already
    // normalised, or a -1.0 sample that cannot be normalised further.
    function automatic logic is_pass_through(input int bw, input int dw);
        return (bw == 0) || (bw == dw - 1) || (bw == dw);
    endfunction

    // Largest value the block-exponent accumulator can hold before it sticks.
    function automatic int exp_sat_max(input int expw);
        return (1 << expw) - 1;
    endfunction

endpackage

// File: rtl/bfp_scale_ctrl_if.sv
// Handshake and data bundle between the butterfly pipeline and the scale
// controller. The sat_flag signal exists only when BFP_SAT_DETECT_EN is defined.
interface bfp_scale_ctrl_if #(
    parameter int FFT_DW    = 16,
    parameter int FFT_BFPDW = 5,
    parameter int FFT_EXPW  = 6
);
    logic                 fft_start;
    logic                 stage_start;
    logic                 stage_end;
    logic                 din_valid;
    logic [FFT_DW-1:0]    din_re;
    logic [FFT_DW-1:0]    din_im;
    logic [FFT_BFPDW-1:0] bw_out;
    logic                 bw_update;
    logic [FFT_EXPW-1:0]  exp_out;
    logic                 busy;
    logic                 protocol_err;
`ifdef BFP_SAT_DETECT_EN
    logic                 sat_flag;
`endif

    modport master (
        output fft_start, stage_start, stage_end, din_valid, din_re, din_im,
        input  bw_out, bw_update, exp_out, busy, protocol_err
`ifdef BFP_SAT_DETECT_EN
        , input sat_flag
`endif
    );

    modport slave (
        input  fft_start, stage_start, stage_end, din_valid, din_re, din_im,
        output bw_out, bw_update, exp_out, busy, protocol_err
`ifdef BFP_SAT_DETECT_EN
        , output sat_flag
`endif
    );

endinterface

// File: rtl/bfp_scale_ctrl_bitwidth.sv
// Combinational significant-bit-length detector for one two's complement sample.
module bfp_bitwidth #(
    parameter int FFT_DW    = 16,
    parameter int FFT_BFPDW = 5
) (
    input  logic [FFT_DW-1:0]    din,
    output logic [FFT_BFPDW-1:0] bw
);

    logic [FFT_DW-1:0] mag;

    // Magnitude then highest set bit; negating the most-negative value wraps
    // back to itself, so its top bit lands on FFT_DW without a special case.
    always_comb begin
        mag = din[FFT_DW-1] ? -din : din;
        bw  = '0;
        for (int i = 0; i < FFT_DW; i++) begin
            if (mag[i]) begin
                bw = FFT_BFPDW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/bfp_scale_ctrl.sv
// Block-floating-point scale controller: tracks the widest butterfly output
// of each FFT stage, publishes it to the shifter, and accumulates the block
// exponent. Optional macro BFP_SAT_DETECT_EN adds a sticky sat_flag output.
module bfp_scale_ctrl
    import bfp_pkg::*;
#(
    parameter int FFT_DW    = FFT_DW_DEFAULT,
    parameter int FFT_BFPDW = FFT_BFPDW_DEFAULT,
    parameter int FFT_EXPW  = FFT_EXPW_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    bfp_scale_ctrl_if.slave bus
);

    localparam int EXP_MAX = exp_sat_max(FFT_EXPW);

    bfp_state_t           state;
    logic                 drain_cnt;
    logic                 accept;
    logic [FFT_BFPDW-1:0] bw_re;
    logic [FFT_BFPDW-1:0] bw_im;
    logic                 p1_valid;
    logic [FFT_BFPDW-1:0] p1_bw_re;
    logic [FFT_BFPDW-1:0] p1_bw_im;
    logic [FFT_BFPDW-1:0] p1_max;
    logic [FFT_BFPDW-1:0] stage_max;
    logic [FFT_BFPDW-1:0] stage_max_next;
    logic [FFT_EXPW-1:0]  shift;
    logic [FFT_EXPW:0]    exp_sum;
    logic [FFT_EXPW-1:0]  exp_next;
    logic [FFT_BFPDW-1:0] bw_hold;
    logic                 update_pulse;
    logic [FFT_EXPW-1:0]  exp_acc;
    logic                 busy_flag;
    logic                 err_flag;
`ifdef BFP_SAT_DETECT_EN
    logic                 sat_seen;
`endif

    bfp_bitwidth #(.FFT_DW(FFT_DW), .FFT_BFPDW(FFT_BFPDW)) u_bw_re (
        .din (bus.din_re),
        .bw  (bw_re)
    );

    bfp_bitwidth #(.FFT_DW(FFT_DW), .FFT_BFPDW(FFT_BFPDW)) u_bw_im (
        .din (bus.din_im),
        .bw  (bw_im)
    );

    // Only samples arriving inside an open window are counted.
    assign accept = bus.din_valid && (state == ACCUM);

    // First pipeline stage: capture both component widths of an accepted sample.
    always_ff @(posedge clk) begin
        if (rst || bus.fft_start) begin
            p1_valid <= 1'b0;
            p1_bw_re <= '0;
            p1_bw_im <= '0;
        end else begin
            p1_valid <= accept;
            p1_bw_re <= bw_re;
            p1_bw_im <= bw_im;
        end
    end

    // Running stage maximum and the exponent the shifter will add this stage.
    always_comb begin
        p1_max         = (p1_bw_re > p1_bw_im) ? p1_bw_re : p1_bw_im;
        stage_max_next = stage_max;
        if (p1_valid && (p1_max > stage_max)) begin
            stage_max_next = p1_max;
        end
        if (is_pass_through(int'(stage_max), FFT_DW)) begin
            shift = '0;
        end else begin
            shift = FFT_EXPW'(FFT_DW - 1 - int'(stage_max));
        end
        exp_sum = {1'b0, exp_acc} + {1'b0, shift};
        if (exp_sum > (FFT_EXPW + 1)'(EXP_MAX)) begin
            exp_next = FFT_EXPW'(EXP_MAX);
        end else begin
            exp_next = exp_sum[FFT_EXPW-1:0];
        end
    end

    // Stage sequencing with all outward-facing state registered here; the
    // two DRAIN cycles let the last in-window sample reach stage_max.
    always_ff @(posedge clk) begin
        if (rst || bus.fft_start) begin
            state        <= IDLE;
            drain_cnt    <= 1'b0;
            stage_max    <= '0;
            bw_hold      <= '0;
            update_pulse <= 1'b0;
            exp_acc      <= '0;
            busy_flag    <= 1'b0;
            err_flag     <= 1'b0;
`ifdef BFP_SAT_DETECT_EN
            sat_seen     <= 1'b0;
`endif
        end else begin
            update_pulse <= 1'b0;
            stage_max    <= stage_max_next;
            case (state)
                IDLE: begin
                    if (bus.stage_start) begin
                        stage_max <= '0;
                        busy_flag <= 1'b1;
                        drain_cnt <= 1'b0;
                        state     <= bus.stage_end ? DRAIN : ACCUM;
                    end else if (bus.stage_end) begin
                        err_flag <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (bus.stage_start) begin
                        err_flag <= 1'b1;
                    end
                    if (bus.stage_end) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.stage_start || bus.stage_end || bus.din_valid) begin
                        err_flag <= 1'b1;
                    end
                    if (drain_cnt) begin
                        state <= PUBLISH;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                PUBLISH: begin
                    if (bus.stage_start || bus.stage_end) begin
                        err_flag <= 1'b1;
                    end
                    bw_hold      <= stage_max;
                    update_pulse <= 1'b1;
                    busy_flag    <= 1'b0;
                    exp_acc      <= exp_next;
`ifdef BFP_SAT_DETECT_EN
                    if (stage_max == FFT_BFPDW'(FFT_DW)) begin
                        sat_seen <= 1'b1;
                    end
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bw_out       = bw_hold;
    assign bus.bw_update    = update_pulse;
    assign bus.exp_out      = exp_acc;
    assign bus.busy         = busy_flag;
    assign bus.protocol_err = err_flag;
`ifdef BFP_SAT_DETECT_EN
    assign bus.sat_flag     = sat_seen;
`endif

endmodule

// File: tb/tb_bfp_scale_ctrl.sv
// Self-checking bench for bfp_scale_ctrl: directed scenarios plus randomized
// stages compared against an arithmetic reference model.
// Honours BFP_SAT_DETECT_EN when defined.
module tb_bfp_scale_ctrl;

    localparam int DW    = 16;
    localparam int BFPDW = 5;
    localparam int EXPW  = 6;

    logic clk = 1'b0;
    logic rst;

    int num_checks = 0;
    int num_errors = 0;

    int model_max;
    int model_exp;
    bit model_err;
    bit model_sat;

    logic [DW-1:0] q_re[$];
    logic [DW-1:0] q_im[$];

    bfp_scale_ctrl_if #(.FFT_DW(DW), .FFT_BFPDW(BFPDW), .FFT_EXPW(EXPW)) bus ();

    bfp_scale_ctrl #(.FFT_DW(DW), .FFT_BFPDW(BFPDW), .FFT_EXPW(EXPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hang guard
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        num_checks++;
        if (got !== want) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference bit length: count halvings of the absolute value.
    function automatic int ref_bw(input logic [DW-1:0] x);
        int v;
        int n;
        v = int'($signed(x));
        if (v < 0) v = -v;
        n = 0;
        while (v > 0) begin
            n++;
            v = v / 2;
        end
        return n;
    endfunction

    function automatic int ref_shift(input int m);
        if (m == 0 || m == DW - 1 || m == DW) return 0;
        return (DW - 1) - m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fft_start   = 1'b0;
        bus.stage_start = 1'b0;
        bus.stage_end   = 1'b0;
        bus.din_valid   = 1'b0;
        bus.din_re      = '0;
        bus.din_im      = '0;
    endtask

    task automatic model_clear();
        model_max = 0;
        model_exp = 0;
        model_err = 1'b0;
        model_sat = 1'b0;
    endtask

    task automatic check_sat(input string tag);
`ifdef BFP_SAT_DETECT_EN
        checkOutput(tag, bus.sat_flag, model_sat);
`else
        if (tag.len() < 0) $display("[TB] %s", tag);
`endif
    endtask

    task automatic do_fft_start();
        bus.fft_start = 1'b1;
        tick();
        bus.fft_start = 1'b0;
        model_clear();
        checkOutput("fft_start_exp", bus.exp_out, 0);
        checkOutput("fft_start_bw", bus.bw_out, 0);
        checkOutput("fft_start_err", bus.protocol_err, 0);
        checkOutput("fft_start_busy", bus.busy, 0);
        check_sat("fft_start_sat");
    endtask

    // Wait for the publish pulse; ticks_done counts edges already spent after
    // the edge that sampled stage_end.
    task automatic await_publish(input int ticks_done);
        int waited;
        waited = ticks_done;
        while (bus.bw_update !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        checkOutput("publish_latency", waited, 3);
        model_exp = model_exp + ref_shift(model_max);
        if (model_exp > 63) model_exp = 63;
        if (model_max == DW) model_sat = 1'b1;
        checkOutput("bw_out", bus.bw_out, model_max);
        checkOutput("exp_out", bus.exp_out, model_exp);
        checkOutput("busy_at_publish", bus.busy, 0);
        checkOutput("protocol_err", bus.protocol_err, model_err);
        check_sat("sat_flag");
        tick();
        checkOutput("bw_update_one_cycle", bus.bw_update, 0);
        checkOutput("bw_out_held", bus.bw_out, model_max);
    endtask

    // Run one stage over the queued samples; optionally close the window on
    // the last sample and poke din_valid during the drain.
    task automatic applyStimulus(input bit end_with_last, input bit drain_poke, input int gap_pct);
        int ticks;
        int b;
        bus.stage_start = 1'b1;
        tick();
        bus.stage_start = 1'b0;
        checkOutput("busy_after_start", bus.busy, 1);
        model_max = 0;
        for (int i = 0; i < q_re.size(); i++) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(99) < gap_pct) begin
                    bus.din_valid = 1'b0;
                    tick();
                end
            end
            bus.din_valid = 1'b1;
            bus.din_re    = q_re[i];
            bus.din_im    = q_im[i];
            if (end_with_last && i == q_re.size() - 1) bus.stage_end = 1'b1;
            b = ref_bw(q_re[i]);
            if (b > model_max) model_max = b;
            b = ref_bw(q_im[i]);
            if (b > model_max) model_max = b;
            tick();
        end
        if (!end_with_last || q_re.size() == 0) begin
            bus.din_valid = 1'b0;
            bus.stage_end = 1'b1;
            tick();
        end
        bus.stage_end = 1'b0;
        bus.din_valid = 1'b0;
        ticks = 0;
        if (drain_poke) begin
            bus.din_valid = 1'b1;
            bus.din_re    = 16'h7FFF;
            bus.din_im    = 16'h8000;
            model_err     = 1'b1;
            tick();
            bus.din_valid = 1'b0;
            ticks = 1;
        end
        await_publish(ticks);
    endtask

    task automatic load1(input logic [DW-1:0] re, input logic [DW-1:0] im);
        q_re.delete();
        q_im.delete();
        q_re.push_back(re);
        q_im.push_back(im);
    endtask

    function automatic logic [DW-1:0] rand_sample();
        int sel;
        logic [DW-1:0] v;
        sel = $urandom_range(9);
        if (sel == 0) return '0;
        if (sel == 1) return 16'h8000;
        if (sel == 2) return 16'hFFFF;
        v = DW'($urandom_range(65535) >> $urandom_range(15));
        if ($urandom_range(1) == 1) v = -v;
        return v;
    endfunction

    initial begin
        int pulses;
        clear_inputs();
        model_clear();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("reset_bw", bus.bw_out, 0);
        checkOutput("reset_update", bus.bw_update, 0);
        checkOutput("reset_exp", bus.exp_out, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_err", bus.protocol_err, 0);

        // Mixed-magnitude stage then wide, zero and -1.0 stages
        do_fft_start();
        q_re = '{16'h0100, 16'h0800};
        q_im = '{16'h0040, 16'h0000};
        applyStimulus(1'b0, 1'b0, 0);
        load1(16'h4000, 16'h0000);
        applyStimulus(1'b0, 1'b0, 0);
        load1(16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, 0);
        load1(16'h8000, 16'h0000);
        applyStimulus(1'b0, 1'b0, 0);

        // Empty window: stage_start and stage_end together
        bus.stage_start = 1'b1;
        bus.stage_end   = 1'b1;
        tick();
        bus.stage_start = 1'b0;
        bus.stage_end   = 1'b0;
        model_max = 0;
        checkOutput("busy_empty_window", bus.busy, 1);
        await_publish(0);

        // Small negative samples until the exponent saturates
        do_fft_start();
        for (int k = 0; k < 6; k++) begin
            load1(16'h0000, 16'hFFFF);
            applyStimulus(1'b0, 1'b0, 0);
        end

        // Sample on the stage_end cycle, plus an illegal drain sample
        load1(16'h1000, 16'h0000);
        applyStimulus(1'b1, 1'b1, 0);

        // Reset while draining aborts the stage
        bus.stage_start = 1'b1;
        tick();
        bus.stage_start = 1'b0;
        bus.din_valid   = 1'b1;
        bus.din_re      = 16'h2000;
        bus.stage_end   = 1'b1;
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        checkOutput("rst_drain_bw", bus.bw_out, 0);
        checkOutput("rst_drain_update", bus.bw_update, 0);
        checkOutput("rst_drain_exp", bus.exp_out, 0);
        checkOutput("rst_drain_busy", bus.busy, 0);
        checkOutput("rst_drain_err", bus.protocol_err, 0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.bw_update === 1'b1) pulses++;
        end
        checkOutput("rst_drain_no_update", pulses, 0);

        // stage_start while busy is rejected and flagged
        bus.stage_start = 1'b1;
        tick();
        tick();
        bus.stage_start = 1'b0;
        model_err = 1'b1;
        checkOutput("start_while_busy_err", bus.protocol_err, 1);
        bus.stage_end = 1'b1;
        tick();
        bus.stage_end = 1'b0;
        model_max = 0;
        await_publish(0);

        // stage_end with no open window is flagged
        do_fft_start();
        bus.stage_end = 1'b1;
        tick();
        bus.stage_end = 1'b0;
        model_err = 1'b1;
        checkOutput("end_in_idle_err", bus.protocol_err, 1);
        checkOutput("end_in_idle_busy", bus.busy, 0);

        // Randomized stages
        for (int s = 0; s < 30; s++) begin
            int n;
            if (s % 6 == 0) do_fft_start();
            n = $urandom_range(1, 5);
            q_re.delete();
            q_im.delete();
            for (int i = 0; i < n; i++) begin
                q_re.push_back(rand_sample());
                q_im.push_back(rand_sample());
            end
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(3) == 0), 30);
        end

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule

// File: doc/bfp_scale_ctrl.md
Name: bfp_scale_ctrl

Overview:
- Block-floating-point scale controller for the radix-2 FFT butterfly pipeline.
- During each FFT stage it monitors butterfly output samples and tracks the maximum significant bit width `bw` over the stage.
- At stage end it publishes `bw` to the bfp shifter for the next stage, and accumulates the applied shift into a per-transform block exponent.

Parameters:
- FFT_DW, 16: sample width (two's complement, per real/imag component).
- FFT_BFPDW, 5: width of `bw`; must hold values 0..FFT_DW.
- FFT_EXPW, 6: width of the block-exponent accumulator.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- fft_start, input, 1: pulse; begins a new transform, clears exponent and `bw`.
- stage_start, input, 1: pulse; opens a stage accumulation window.
- stage_end, input, 1: pulse; closes the window (sample on same cycle is included).
- din_valid, input, 1: butterfly output sample valid.
- din_re, input, FFT_DW: real component.
- din_im, input, FFT_DW: imaginary component.
- bw_out, output, FFT_BFPDW: stage max bit width, drives shifter `bw`.
- bw_update, output, 1: one-cycle pulse when bw_out is updated.
- exp_out, output, FFT_EXPW: accumulated block exponent (total left shift applied).
- busy, output, 1: high from stage_start acceptance until bw_update.
- protocol_err, output, 1: sticky protocol violation flag.

Behaviour:
- Reset (and fft_start): state IDLE, bw_out=0, bw_update=0, exp_out=0, busy=0, protocol_err=0, stage max=0, pipeline valid=0. fft_start has priority over all other inputs in any state.
- Bit width of x:
  - x==0 → 0.
  - x==most-negative (1<<(DW-1)) → FFT_DW.
  - Otherwise, bit length of |x| (1..DW-1). Example: 0x4000 → 15; 0xC000 → 15; 0xFFFF → 1; 0x0001 → 1.
- Pipeline:
  - P1 registers bw(din_re), bw(din_im), and valid on the edge after din_valid.
  - P2 updates stage_max = max(stage_max, bw_re, bw_im) on the following edge.
- FSM states: IDLE, ACCUM, DRAIN (2 cycles, 1-bit counter), PUBLISH.
  - IDLE: stage_start → ACCUM, clear stage_max, busy=1.
  - ACCUM: samples with din_valid accepted; stage_end → DRAIN.
  - DRAIN: 2 cycles to flush P1/P2; din_valid here is ignored and sets protocol_err.
  - PUBLISH (1 cycle): bw_out<=stage_max, bw_update=1 next cycle, busy deasserts with bw_update; exp update; → IDLE.
- Latency: stage_end at cycle T → bw_update and new bw_out visible at T+4.
- Exponent update: shift = 0 if stage_max ∈ {0, DW-1, DW}, else (DW-1)-stage_max. This mirrors the shifter pass-through rule. exp_out += shift, saturating at 2^FFT_EXPW-1.
- Simultaneous stage_start+stage_end in IDLE: window of zero samples; publishes 0, shift 0.
- Errors: stage_start outside IDLE and stage_end outside ACCUM are ignored and set protocol_err. din_valid in IDLE is ignored silently.
- rst mid-stage aborts; no bw_update is emitted.

Optional Feature:
- Macro BFP_SAT_DETECT_EN.
- Defined:
  - Adds output `sat_flag` (1 bit), sticky until fft_start/rst.
  - Set in PUBLISH when stage_max==FFT_DW (a -1.0 sample seen, shifter cannot normalise).
- Undefined: port absent; no extra logic.

Decomposition:
- Package bfp_pkg:
  - FSM state enum (IDLE, ACCUM, DRAIN, PUBLISH).
  - Function/constant for pass-through bw set.
  - Exponent saturation constant.
- Sub-module bfp_bitwidth: combinational bit-length detector, FFT_DW in / FFT_BFPDW out, instantiated twice (re, im).

Test Plan:
- fft_start; stage_start; samples re=0x0100, im=0x0040, then re=0x0800, im=0; stage_end → bw_update at T+4, bw_out=12, exp_out=3.
- Next stage: sample re=0x4000 → bw_out=15, exp_out stays 3; then a stage with only zero samples → bw_out=0, exp unchanged.
- Stage containing re=0x8000 → bw_out=16, shift 0; with BFP_SAT_DETECT_EN, sat_flag=1 until fft_start.
- Negative magnitudes: im=0xFFFF alone → bw_out=1, shift 14; repeat until exp saturates → exp_out holds 63.
- stage_end on same cycle as din_valid re=0x1000 → sample counted, bw_out=13; din_valid during DRAIN → protocol_err=1, bw_out unaffected.
- rst asserted in DRAIN → no bw_update, all outputs 0 next cycle; stage_start while busy → ignored, protocol_err=1.
